alu_cmd_sequencer: RTL and testbench

Command-side driver for the 4-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and drives registered a/b/op onto the ALU. It captures the 5-bit ALU result, flags illegal opcodes, and returns in-order responses over a second valid/ready handshake through a small response FIFO. It sits between a test/control master and the ALU instance. It also keeps issued-op and illegal-op counters.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_rsp_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 99 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, widths and sequencer states.
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 5;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD        = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB        = 3'b001;
    localparam logic [OP_W-1:0] OP_AND        = 3'b010;
    localparam logic [OP_W-1:0] OP_OR         = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR        = 3'b100;
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = 3'b100;

    typedef enum logic {
        IDLE,
        ISSUE
    } seq_state_t;

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; the head is presented combinationally and reads as zero when empty.
module alu_rsp_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives registered operands/opcode to an external ALU, captures its result one cycle later
// and returns in-order responses through a small FIFO, with issued and illegal-op counters.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [4:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_result,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    seq_state_t      state;
    logic            err_q;
    logic            push;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [RES_W:0]  head;

    // Only one command is ever in flight, so a free slot at accept time covers the later push.
    assign cmd_ready  = !rst && (state == IDLE) && (fifo_count < DEPTH_C);
    assign push       = (state == ISSUE);
    assign rsp_valid  = !fifo_empty;
    assign rsp_result = head[RES_W:1];
    assign rsp_err    = head[0];

    alu_rsp_fifo #(
        .WIDTH (RES_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({alu_result, err_q}),
        .pop       (rsp_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            err_q     <= 1'b0;
            op_count  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a  <= cmd_a;
                        alu_b  <= cmd_b;
                        alu_op <= cmd_op;
                        err_q  <= is_illegal(cmd_op);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    op_count <= op_count + 1'b1;
                    if (err_q) begin
                        err_count <= err_count + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (!fifo_full);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed vector table, multi-cycle corner sequences and a
// randomized run, all checked against a transaction-level model of the response stream.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [2:0]       cmd_op;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_op;
    logic [4:0]       alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [4:0]       rsp_result;
    logic             rsp_err;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    alu_cmd_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .op_count   (op_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 4-bit ALU the sequencer drives.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  alu_result = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_result = {1'b0, alu_a & alu_b};
            3'b011:  alu_result = {1'b0, alu_a | alu_b};
            3'b100:  alu_result = {1'b0, alu_a ^ alu_b};
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {result, err} from plain integer arithmetic on the command fields.
    function automatic logic [5:0] model_rsp(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = (a + b) % 32;
            1:       r = (a - b + 32) % 32;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            default: r = 0;
        endcase
        return {5'(r), op > 4};
    endfunction

    // Transaction model: queued responses, one in-flight slot, completion counts.
    logic [5:0] exp_q[$];
    bit         mon_on     = 0;
    bit         m_inflight = 0;
    bit         m_ready;
    logic [5:0] m_pending  = '0;
    int         m_ops      = 0;
    int         m_errs     = 0;
    int         acc_cnt    = 0;
    logic [3:0] m_a        = '0;
    logic [3:0] m_b        = '0;
    logic [2:0] m_op       = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            m_ready = !rst && !m_inflight && (exp_q.size() < DEPTH);
            chk("cmd_ready", cmd_ready, m_ready);
            chk("rsp_valid", rsp_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("rsp_result", rsp_result, exp_q[0][5:1]);
                chk("rsp_err", rsp_err, exp_q[0][0]);
            end
            chk("op_count", op_count, m_ops & 32'hFF);
            chk("err_count", err_count, m_errs & 32'hFF);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
            if (rst) begin
                exp_q.delete();
                m_inflight = 0;
                m_ops      = 0;
                m_errs     = 0;
                m_a        = '0;
                m_b        = '0;
                m_op       = '0;
            end else begin
                if (exp_q.size() != 0 && rsp_ready) begin
                    void'(exp_q.pop_front());
                end
                if (m_inflight) begin
                    exp_q.push_back(m_pending);
                    m_ops++;
                    if (m_pending[0]) m_errs++;
                    m_inflight = 0;
                end else if (cmd_valid && m_ready) begin
                    m_inflight = 1;
                    m_pending  = model_rsp(cmd_a, cmd_b, cmd_op);
                    m_a        = cmd_a;
                    m_b        = cmd_b;
                    m_op       = cmd_op;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Offers one command and returns 1ns after the edge that accepted it.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bit hs;
        int n;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        hs        = 0;
        n         = 0;
        while (!hs && n < 300) begin
            @(negedge clk);
            hs = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL send_timeout: command a=%0h b=%0h op=%0h never accepted", a, b, op);
        end
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while ((rsp_valid || dut.state == alu_pkg::ISSUE) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", rsp_valid, 0);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [4:0] res;
        logic       err;
        int         ops;
        int         errs;
    } vec_t;

    vec_t vecs[7];
    bit   done;
    int   n_ill;

    initial begin
        vecs[0] = '{4'd9, 4'd8, 3'b000, 5'd17, 1'b0, 1, 0};
        vecs[1] = '{4'd3, 4'd5, 3'b001, 5'd30, 1'b0, 2, 0};
        vecs[2] = '{4'hC, 4'hA, 3'b010, 5'h08, 1'b0, 3, 0};
        vecs[3] = '{4'hF, 4'h5, 3'b100, 5'h0A, 1'b0, 4, 0};
        vecs[4] = '{4'd7, 4'd2, 3'b110, 5'd0,  1'b1, 5, 1};
        vecs[5] = '{4'h5, 4'hA, 3'b011, 5'h0F, 1'b0, 6, 1};
        vecs[6] = '{4'hF, 4'hF, 3'b111, 5'd0,  1'b1, 7, 2};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        tick();
        mon_on = 1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Directed vectors: latency, result values, error flag and counters.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op);
            chk("vec_alu_a", alu_a, vecs[i].a);
            chk("vec_alu_b", alu_b, vecs[i].b);
            chk("vec_alu_op", alu_op, vecs[i].op);
            chk("vec_early_valid", rsp_valid, 0);
            tick();
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_result", rsp_result, vecs[i].res);
            chk("vec_rsp_err", rsp_err, vecs[i].err);
            chk("vec_op_count", op_count, vecs[i].ops);
            chk("vec_err_count", err_count, vecs[i].errs);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("vec_alu_hold", {alu_a, alu_b, alu_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
        end

        // Backpressure: six commands against a stalled consumer.
        do_reset();
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(4'(i), 4'(i + 1), 3'(i % 5));
                end
            end
            begin
                repeat (12) tick();
                chk("bp_accepted", acc_cnt, 4);
                chk("bp_cmd_ready", cmd_ready, 0);
                chk("bp_op_count", op_count, 4);
                for (int k = 0; k < 4; k++) begin
                    chk("bp_head_stable", {rsp_valid, rsp_result, rsp_err},
                        {1'b1, model_rsp(0, 1, 0)});
                    chk("bp_still_blocked", cmd_ready, 0);
                    tick();
                end
                rsp_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total_accepted", acc_cnt, 6);
        chk("bp_final_count", op_count, 6);

        // Reset while a command is in flight with two responses queued.
        do_reset();
        send(4'd1, 4'd1, 3'b000);
        send(4'd2, 4'd2, 3'b000);
        send(4'd3, 4'd3, 3'b000);
        rst = 1'b1;
        tick();
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_op_count", op_count, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        tick();
        chk("midrst_ready_after", cmd_ready, 1);
        send(4'd6, 4'd7, 3'b000);
        tick();
        chk("midrst_single_valid", rsp_valid, 1);
        chk("midrst_single_result", rsp_result, 13);
        chk("midrst_single_count", op_count, 1);
        rsp_ready = 1'b1;
        tick();
        chk("midrst_single_only", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Counter wrap with continuous push/pop overlap.
        do_reset();
        rsp_ready = 1'b1;
        n_ill = 0;
        for (int i = 0; i < 256; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op > 3'b100) n_ill++;
            send(4'($urandom), 4'($urandom), op);
        end
        tick();
        chk("wrap_op_count", op_count, 0);
        chk("wrap_err_count", err_count, n_ill & 255);
        drain();

        // Randomized traffic with random consumer stalls and command gaps.
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(4'($urandom), 4'($urandom), 3'($urandom));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        drain();
        chk("rand_op_count", op_count, m_ops & 32'hFF);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
